lsu_rmw: RTL

Load/store unit between the core's execute stage and `deta_mem`. It accepts one byte/halfword/word request at a time, drives `deta_mem` with word-aligned addresses, and sign- or zero-extends load data. It runs sub-word stores as a two-cycle read-modify-write, because `deta_mem` writes only whole 32-bit words. The core stalls on `req_ready`.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_lane.sv | 55 +++++
 rtl/lsu_rmw.sv | 119 +++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and alignment helper for the load/store unit
//
// Holds the request size encodings, the control state encoding and the
// misalignment rule used when a request is accepted.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RMW  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Halves must sit on even addresses, words on multiples of four.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - little-endian lane extract/extend or merge, purely combinational
//
// Ports:
//   word        in  32  memory word (load source, or old word for a merge)
//   wdata       in  32  right-justified store data (merge only)
//   lane        in  2   byte address within the word
//   size        in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   is_unsigned in  1   zero-extend instead of sign-extend (extract only)
//   result      out 32  extended load data (MERGE=0) or merged store word (MERGE=1)
module lsu_lane
  import lsu_pkg::*;
#(
  parameter bit MERGE = 1'b0
) (
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] ext;
  logic [31:0] mask;
  logic [31:0] rep;
  logic [31:0] merged;

  assign shamt = {lane, 3'b000};

  always_comb begin
    shifted = word >> shamt;
    ext     = shifted;
    mask    = 32'hFFFF_FFFF;
    rep     = wdata;
    case (size)
      SZ_BYTE: begin
        ext  = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
        mask = 32'h0000_00FF << shamt;
        rep  = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        ext  = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
        mask = 32'h0000_FFFF << shamt;
        rep  = {2{wdata[15:0]}};
      end
      default: ;
    endcase
    // Replicating the store data puts it in every lane; the mask keeps only the addressed one.
    merged = (word & ~mask) | (rep & mask);
    result = MERGE ? merged : ext;
  end

endmodule

// File: rtl/lsu_rmw.sv
// rtl/lsu_rmw.sv - load/store unit with read-modify-write sub-word stores
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake; ready only in IDLE
//   req_we, req_size            store flag, size (byte/half/word/illegal)
//   req_unsigned                zero-extend loads
//   req_addr, req_wdata         byte address, right-justified store data
//   rsp_valid                   one-cycle completion pulse
//   rsp_rdata, rsp_err          extended load data, error flag
//   mem_addr                    word-aligned memory address
//   mem_write_en, mem_wdata     whole-word memory write
//   mem_rdata                   combinational memory read data
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        state;
  logic [ADDR_W-3:0] r_waddr;
  logic [1:0]        r_lane;
  logic [1:0]        r_size;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_old;

  logic        req_err;
  logic        accept;
  logic        word_store;
  logic        sub_store;
  logic [31:0] ext_data;
  logic [31:0] merge_data;

  assign req_err = (req_size == SZ_ILL) | misaligned(req_size, req_addr[1:0]);

  // Gating with rst_n keeps the combinational word-store write quiet while reset is held.
  assign accept     = rst_n & (state == ST_IDLE) & req_valid;
  assign word_store = accept & req_we & ~req_err & (req_size == SZ_WORD);
  assign sub_store  = accept & req_we & ~req_err & (req_size != SZ_WORD);

  assign req_ready    = (state == ST_IDLE);
  assign rsp_valid    = (state == ST_RESP);
  assign mem_addr     = (state == ST_IDLE) ? {req_addr[ADDR_W-1:2], 2'b00} : {r_waddr, 2'b00};
  assign mem_write_en = word_store | (state == ST_RMW);
  assign mem_wdata    = word_store          ? req_wdata  :
                        (state == ST_RMW)   ? merge_data : '0;

  lsu_lane #(.MERGE(1'b0)) u_extract (
    .word        (mem_rdata),
    .wdata       (32'h0),
    .lane        (req_addr[1:0]),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .result      (ext_data)
  );

  lsu_lane #(.MERGE(1'b1)) u_merge (
    .word        (r_old),
    .wdata       (r_wdata),
    .lane        (r_lane),
    .size        (r_size),
    .is_unsigned (1'b0),
    .result      (merge_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      r_waddr   <= '0;
      r_lane    <= 2'b00;
      r_size    <= SZ_BYTE;
      r_wdata   <= '0;
      r_old     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            rsp_err   <= req_err;
            rsp_rdata <= (!req_err && !req_we) ? ext_data : '0;
            if (sub_store) begin
              r_waddr <= req_addr[ADDR_W-1:2];
              r_lane  <= req_addr[1:0];
              r_size  <= req_size;
              r_wdata <= req_wdata;
              r_old   <= mem_rdata;
              state   <= ST_RMW;
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_RMW:  state <= ST_RESP;
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
